// File: rtl/reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and constants for the reset sequencer:
//   - seq_state_e : FSM state codes (also driven out on state_dbg)
//   - DBG_*       : state_dbg encodings for software / bench visibility
//   - stage_mask  : mask of stages whose ready must stay asserted
// ---------------------------------------------------------------------------
package reset_seq_pkg;

   typedef enum logic [2:0] {
      ST_HOLD       = 3'd0,
      ST_RELEASE    = 3'd1,
      ST_WAIT_READY = 3'd2,
      ST_GAP        = 3'd3,
      ST_RUN        = 3'd4
   } seq_state_e;

   localparam logic [2:0] DBG_HOLD       = 3'd0;
   localparam logic [2:0] DBG_RELEASE    = 3'd1;
   localparam logic [2:0] DBG_WAIT_READY = 3'd2;
   localparam logic [2:0] DBG_GAP        = 3'd3;
   localparam logic [2:0] DBG_RUN        = 3'd4;

   // Stages below idx are always covered; idx itself only once it has
   // already reported ready (incl = 1).
   function automatic logic [7:0] stage_mask(input logic [2:0] idx,
                                             input logic       incl);
      logic [7:0] mask;
      mask = 8'h00;
      for (int i = 0; i < 8; i++) begin
         mask[i] = (3'(i) < idx) || (incl && (3'(i) == idx));
      end
      return mask;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer with asynchronous active-high reset to RESET_VAL.
// Ports:
//   clk      : destination clock
//   reset_in : asynchronous active-high reset (loads RESET_VAL)
//   d        : asynchronous input vector
//   q        : synchronized output (2 clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         meta_r <= RESET_VAL;
         sync_r <= RESET_VAL;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Turns one global reset into ordered per-stage resets. After a hold time,
// stage k is released, its ready is awaited, a gap elapses, then stage k+1
// is released. Timeouts, soft requests and ready loss re-run the sequence.
// Ports:
//   clk            : free-running sequencer clock
//   reset_in       : asynchronous active-high reset (release synchronized)
//   stage_ready    : per-stage ready, asynchronous, synchronized internally
//   soft_reset_req : single-cycle pulse requesting a full re-sequence
//   reset_out      : registered active-high stage resets, bit 0 first
//   all_released   : high while in RUN
//   timeout_err    : sticky ready-timeout flag, cleared only by reset_in
//   state_dbg      : current FSM state code
// ---------------------------------------------------------------------------
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES    = 3,
   parameter int HOLD_CYCLES   = 256,
   parameter int GAP_CYCLES    = 64,
   parameter int READY_TIMEOUT = 1048576,
   parameter int CNT_W         = 21
) (
   input  logic                  clk,
   input  logic                  reset_in,
   input  logic [NUM_STAGES-1:0] stage_ready,
   input  logic                  soft_reset_req,
   output logic [NUM_STAGES-1:0] reset_out,
   output logic                  all_released,
   output logic                  timeout_err,
   output logic [2:0]            state_dbg
);

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(READY_TIMEOUT - 1);
   localparam logic [2:0]       LAST_IDX  = 3'(NUM_STAGES - 1);
   localparam logic [NUM_STAGES-1:0] ALL_ONES = {NUM_STAGES{1'b1}};

   localparam longint MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ?
      ((HOLD_CYCLES > READY_TIMEOUT) ? HOLD_CYCLES : READY_TIMEOUT) :
      ((GAP_CYCLES > READY_TIMEOUT) ? GAP_CYCLES : READY_TIMEOUT);

   if (MAX_CNT > (64'd1 << CNT_W)) begin : g_cnt_w_check
      $error("reset_sequencer: CNT_W too narrow for the longest count");
   end
   if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_stages_check
      $error("reset_sequencer: NUM_STAGES must be 1..8");
   end

   logic                  rst_sync_s;
   logic [NUM_STAGES-1:0] rdy_s;
   logic [7:0]            rdy8_s;
   logic [7:0]            idx_onehot_s;
   logic [7:0]            keep_mask_s;
   logic                  loss_s;
   logic                  timeout_hit_s;

   seq_state_e            state_r, state_nx_s;
   logic [CNT_W-1:0]      cnt_r, cnt_nx_s;
   logic [2:0]            idx_r, idx_nx_s;
   logic [NUM_STAGES-1:0] reset_out_r, reset_out_nx_s;
   logic                  all_released_r, all_released_nx_s;
   logic                  timeout_err_r, timeout_err_nx_s;

   // reset_in release is held off for two edges; assertion stays async.
   sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_rst_sync (
      .clk      (clk),
      .reset_in (reset_in),
      .d        (1'b0),
      .q        (rst_sync_s)
   );

   sync_2ff #(.WIDTH(NUM_STAGES), .RESET_VAL({NUM_STAGES{1'b0}})) u_rdy_sync (
      .clk      (clk),
      .reset_in (reset_in),
      .d        (stage_ready),
      .q        (rdy_s)
   );

   // Ready vector widened to 8 so the 3-bit stage index selects it directly.
   always_comb begin
      rdy8_s                 = 8'h00;
      rdy8_s[NUM_STAGES-1:0] = rdy_s;
   end

   // Ready-loss and timeout detection for the current state.
   always_comb begin
      idx_onehot_s = 8'd1 << idx_r;
      case (state_r)
         ST_WAIT_READY: keep_mask_s = stage_mask(idx_r, 1'b0);
         ST_GAP,
         ST_RUN:        keep_mask_s = stage_mask(idx_r, 1'b1);
         default:       keep_mask_s = 8'h00;
      endcase
      loss_s        = |(keep_mask_s & ~rdy8_s);
      timeout_hit_s = (state_r == ST_WAIT_READY) && !rdy8_s[idx_r] &&
                      (cnt_r == TO_LAST);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nx_s        = state_r;
      cnt_nx_s          = cnt_r;
      idx_nx_s          = idx_r;
      reset_out_nx_s    = reset_out_r;
      all_released_nx_s = all_released_r;
      // A soft request in the same cycle as a timeout suppresses the flag.
      timeout_err_nx_s  = timeout_err_r |
                          (timeout_hit_s & ~soft_reset_req & ~rst_sync_s);

      if (rst_sync_s || soft_reset_req || loss_s || timeout_hit_s) begin
         state_nx_s        = ST_HOLD;
         cnt_nx_s          = CNT_ZERO;
         idx_nx_s          = 3'd0;
         reset_out_nx_s    = ALL_ONES;
         all_released_nx_s = 1'b0;
      end else begin
         case (state_r)
            ST_HOLD: begin
               if (cnt_r == HOLD_LAST) begin
                  state_nx_s = ST_RELEASE;
                  cnt_nx_s   = CNT_ZERO;
               end else begin
                  cnt_nx_s   = cnt_r + CNT_ONE;
               end
            end
            ST_RELEASE: begin
               reset_out_nx_s = reset_out_r & ~idx_onehot_s[NUM_STAGES-1:0];
               state_nx_s     = ST_WAIT_READY;
               cnt_nx_s       = CNT_ZERO;
            end
            ST_WAIT_READY: begin
               if (rdy8_s[idx_r]) begin
                  cnt_nx_s = CNT_ZERO;
                  if (idx_r == LAST_IDX) begin
                     state_nx_s        = ST_RUN;
                     all_released_nx_s = 1'b1;
                  end else begin
                     state_nx_s        = ST_GAP;
                  end
               end else begin
                  cnt_nx_s = cnt_r + CNT_ONE;
               end
            end
            ST_GAP: begin
               if (cnt_r == GAP_LAST) begin
                  state_nx_s = ST_RELEASE;
                  idx_nx_s   = idx_r + 3'd1;
                  cnt_nx_s   = CNT_ZERO;
               end else begin
                  cnt_nx_s   = cnt_r + CNT_ONE;
               end
            end
            ST_RUN: begin
               all_released_nx_s = 1'b1;
            end
            default: begin
               state_nx_s        = ST_HOLD;
               cnt_nx_s          = CNT_ZERO;
               idx_nx_s          = 3'd0;
               reset_out_nx_s    = ALL_ONES;
               all_released_nx_s = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; reset_in asserts everything at once.
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         state_r        <= ST_HOLD;
         cnt_r          <= CNT_ZERO;
         idx_r          <= 3'd0;
         reset_out_r    <= ALL_ONES;
         all_released_r <= 1'b0;
         timeout_err_r  <= 1'b0;
      end else begin
         state_r        <= state_nx_s;
         cnt_r          <= cnt_nx_s;
         idx_r          <= idx_nx_s;
         reset_out_r    <= reset_out_nx_s;
         all_released_r <= all_released_nx_s;
         timeout_err_r  <= timeout_err_nx_s;
      end
   end

   assign reset_out    = reset_out_r;
   assign all_released = all_released_r;
   assign timeout_err  = timeout_err_r;
   assign state_dbg    = state_r;

endmodule
